// File: rtl/riscv_pipe_chain.sv
// Reusable chain of pipeline registers with valid/ready backpressure, bubble collapsing and per-stage flush.
// Optional macro RISC_PIPE_PERF_EN builds the saturating stall/bubble counters; otherwise they read as 0.
module riscv_pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                         Clk,
  input  logic                         Reset,
  input  logic                         In_Valid,
  output logic                         In_Ready,
  input  logic [WIDTH-1:0]             In_Data,
  input  logic                         Flush_In,
  input  logic [DEPTH-1:0]             Flush_Mask,
  output logic                         Out_Valid,
  input  logic                         Out_Ready,
  output logic [WIDTH-1:0]             Out_Data,
  output logic [$clog2(DEPTH+1)-1:0]   Count,
  output logic [CNT_W-1:0]             Stall_Cnt,
  output logic [CNT_W-1:0]             Bubble_Cnt
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] r_data [DEPTH];

  logic [DEPTH-1:0] w_live;
  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_in_vld;
  logic [WIDTH-1:0] w_in_data [DEPTH];
  logic             w_acc;

  // A killed stage is treated as empty this cycle, so it can absorb its predecessor.
  always_comb begin
    w_live = r_valid & ~Flush_Mask;
    w_rdy  = '0;
    w_acc  = Out_Ready;
    for (int i = DEPTH-1; i >= 0; i--) begin
      w_acc    = w_acc | ~w_live[i];
      w_rdy[i] = w_acc;
    end
  end

  always_comb begin
    w_in_vld = '0;
    for (int i = 0; i < DEPTH; i++) w_in_data[i] = '0;
    w_in_vld[0]  = In_Valid & ~Flush_In;
    w_in_data[0] = In_Data;
    for (int i = 1; i < DEPTH; i++) begin
      w_in_vld[i]  = w_live[i-1];
      w_in_data[i] = r_data[i-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_rdy[i]) begin
          r_valid[i] <= w_in_vld[i];
          // Payload only moves with a live item; an empty load keeps the old data visible.
          if (w_in_vld[i]) r_data[i] <= w_in_data[i];
        end
      end
    end
  end

  assign In_Ready  = w_rdy[0];
  assign Out_Valid = w_live[DEPTH-1];
  assign Out_Data  = r_data[DEPTH-1];

  always_comb begin
    Count = '0;
    for (int i = 0; i < DEPTH; i++) Count = Count + CW'(r_valid[i]);
  end

`ifdef RISC_PIPE_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (Out_Valid && !Out_Ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (!Out_Valid && Out_Ready && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end
  end

  assign Stall_Cnt  = r_stall_cnt;
  assign Bubble_Cnt = r_bubble_cnt;
`else
  assign Stall_Cnt  = '0;
  assign Bubble_Cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_pipe_chain.sv
// Bench for riscv_pipe_chain: directed scenarios plus a randomized run against a slot-occupancy model.
module tb_riscv_pipe_chain;

  localparam int W     = 32;
  localparam int D     = 4;
  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;
`ifdef RISC_PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // clock / reset
  logic             Clk = 1'b0;
  logic             Reset;
  logic             In_Valid;
  logic             In_Ready;
  logic [W-1:0]     In_Data;
  logic             Flush_In;
  logic [D-1:0]     Flush_Mask;
  logic             Out_Valid;
  logic             Out_Ready;
  logic [W-1:0]     Out_Data;
  logic [2:0]       Count;
  logic [CNT_W-1:0] Stall_Cnt;
  logic [CNT_W-1:0] Bubble_Cnt;

  always #5 Clk = ~Clk;

  riscv_pipe_chain #(.WIDTH(W), .DEPTH(D), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset(Reset),
    .In_Valid(In_Valid), .In_Ready(In_Ready), .In_Data(In_Data),
    .Flush_In(Flush_In), .Flush_Mask(Flush_Mask),
    .Out_Valid(Out_Valid), .Out_Ready(Out_Ready), .Out_Data(Out_Data),
    .Count(Count), .Stall_Cnt(Stall_Cnt), .Bubble_Cnt(Bubble_Cnt)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  // Reference model: slot occupancy and counters, advanced once per cycle.
  bit       m_v [D];
  logic [W-1:0] m_d [D];
  bit       n_v [D];
  logic [W-1:0] n_d [D];
  int       m_stall = 0, m_bub = 0, n_stall = 0, n_bub = 0;

  bit       e_in_ready, e_out_valid;
  logic [W-1:0] e_out_data;
  int       e_count, e_stall, e_bub;

  // Drive one cycle of inputs, derive the expected outputs, then wait for the sampling edge.
  task automatic drive(input bit rst, input bit iv, input logic [W-1:0] id,
                       input bit fi, input logic [D-1:0] fm, input bit ordy);
    bit live [D];
    bit gap;
    bit inc_v;
    logic [W-1:0] inc_d;
    Reset = rst; In_Valid = iv; In_Data = id; Flush_In = fi;
    Flush_Mask = fm; Out_Ready = ordy;
    for (int i = 0; i < D; i++) live[i] = m_v[i] && !fm[i];
    e_count = 0;
    for (int i = 0; i < D; i++) e_count += int'(m_v[i]);
    e_out_valid = live[D-1];
    e_out_data  = m_d[D-1];
    e_stall     = m_stall;
    e_bub       = m_bub;
    e_in_ready  = ordy;
    for (int j = 0; j < D; j++) if (!live[j]) e_in_ready = 1'b1;
    // An occupant moves forward whenever some slot at or beyond it frees up this cycle.
    for (int i = 0; i < D; i++) begin
      gap = ordy;
      for (int j = i; j < D; j++) if (!live[j]) gap = 1'b1;
      inc_v = (i == 0) ? (iv && !fi) : live[i-1];
      inc_d = (i == 0) ? id : m_d[i-1];
      if (gap) begin
        n_v[i] = inc_v;
        n_d[i] = inc_v ? inc_d : m_d[i];
      end else begin
        n_v[i] = m_v[i];
        n_d[i] = m_d[i];
      end
    end
    n_stall = m_stall;
    n_bub   = m_bub;
    if (PERF) begin
      if (e_out_valid && !ordy && m_stall < MAXC) n_stall = m_stall + 1;
      if (!e_out_valid && ordy && m_bub < MAXC)   n_bub   = m_bub + 1;
    end
    if (rst) begin
      for (int i = 0; i < D; i++) begin n_v[i] = 1'b0; n_d[i] = '0; end
      n_stall = 0;
      n_bub   = 0;
    end
    @(negedge Clk);
  endtask

  task automatic tick();
    @(posedge Clk);
    for (int i = 0; i < D; i++) begin m_v[i] = n_v[i]; m_d[i] = n_d[i]; end
    m_stall = n_stall;
    m_bub   = n_bub;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", Out_Valid); end
    checks++; if (Out_Data !== '0) begin errors++; $display("FAIL reset_out_data got=%h exp=0", Out_Data); end
    checks++; if (Count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", Count); end
    checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", In_Ready); end
    checks++; if (Stall_Cnt !== '0) begin errors++; $display("FAIL reset_stall got=%0d exp=0", Stall_Cnt); end
    checks++; if (Bubble_Cnt !== '0) begin errors++; $display("FAIL reset_bubble got=%0d exp=0", Bubble_Cnt); end
    tick();
  endtask

  task automatic test_stream();
    int seen = 0;
    int peak = 0;
    do_reset();
    exp_q.delete();
    for (int c = 0; c < 8; c++) exp_q.push_back(W'(c + 1));
    for (int c = 0; c < 16; c++) begin
      drive(1'b0, c < 8, W'(c + 1), 1'b0, '0, 1'b1);
      if (c < 8) begin
        checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready c=%0d got=%b exp=1", c, In_Ready); end
      end
      if (int'(Count) > peak) peak = int'(Count);
      if (Out_Valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra c=%0d got=%h exp=none", c, Out_Data);
        end else if (Out_Data !== exp_q[0] || c != 4 + seen) begin
          errors++; $display("FAIL stream_data c=%0d got=%h exp=%h at_cycle=%0d", c, Out_Data, exp_q[0], 4 + seen);
          void'(exp_q.pop_front());
        end else void'(exp_q.pop_front());
        seen++;
      end
      tick();
    end
    checks++; if (seen != 8) begin errors++; $display("FAIL stream_count got=%0d exp=8", seen); end
    checks++; if (peak != 4) begin errors++; $display("FAIL stream_peak got=%0d exp=4", peak); end
  endtask

  task automatic test_stall();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      drive(1'b0, 1'b1, W'(32'hA + c), 1'b0, '0, 1'b0);
      tick();
    end
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      checks++; if (In_Ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready c=%0d got=%b exp=0", c, In_Ready); end
      checks++; if (Out_Valid !== 1'b1 || Out_Data !== 32'hA) begin errors++; $display("FAIL stall_hold c=%0d got=%b/%h exp=1/a", c, Out_Valid, Out_Data); end
      checks++; if (Count !== 3'd4) begin errors++; $display("FAIL stall_count c=%0d got=%0d exp=4", c, Count); end
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    checks++; if (Stall_Cnt !== CNT_W'(PERF ? 5 : 0)) begin errors++; $display("FAIL stall_cnt got=%0d exp=%0d", Stall_Cnt, PERF ? 5 : 0); end
    tick();
  endtask

  // Relies on test_stall leaving stages 0..3 = D,C,B,A.
  task automatic test_flush_mask();
    int seen = 0;
    exp_q.delete();
    exp_q.push_back(32'hA);
    exp_q.push_back(32'hD);
    drive(1'b0, 1'b0, '0, 1'b0, 4'b0110, 1'b0);
    checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", In_Ready); end
    tick();
    for (int c = 0; c < 10; c++) begin
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      if (Out_Valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL flush_extra got=%h exp=none", Out_Data);
        end else begin
          if (Out_Data !== exp_q[0]) begin errors++; $display("FAIL flush_order got=%h exp=%h", Out_Data, exp_q[0]); end
          void'(exp_q.pop_front());
        end
        seen++;
      end
      tick();
    end
    checks++; if (seen != 2) begin errors++; $display("FAIL flush_seen got=%0d exp=2", seen); end
  endtask

  task automatic test_flush_in();
    do_reset();
    drive(1'b0, 1'b1, 32'h55, 1'b1, '0, 1'b1);
    checks++; if (In_Ready !== 1'b1) begin errors++; $display("FAIL flushin_ready got=%b exp=1", In_Ready); end
    tick();
    for (int c = 0; c < 6; c++) begin
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      checks++; if (Out_Valid !== 1'b0 || Count !== 3'd0) begin errors++; $display("FAIL flushin_leak c=%0d got=%b/%0d exp=0/0", c, Out_Valid, Count); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(1'b0, 1'b1, W'(32'h11 * (c + 1)), 1'b0, '0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    checks++; if (Out_Valid !== 1'b1 || Out_Data !== 32'h11) begin errors++; $display("FAIL rstmid_pre got=%b/%h exp=1/11", Out_Valid, Out_Data); end
    tick();
    drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    tick();
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    checks++; if (Out_Valid !== 1'b0 || Count !== 3'd0) begin errors++; $display("FAIL rstmid_state got=%b/%0d exp=0/0", Out_Valid, Count); end
    checks++; if (In_Ready !== 1'b1 || Out_Data !== '0) begin errors++; $display("FAIL rstmid_out got=%b/%h exp=1/0", In_Ready, Out_Data); end
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      checks++; if (Out_Valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost c=%0d got=%b exp=0", c, Out_Valid); end
      tick();
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b0, 1'b1, 32'h77, 1'b0, '0, 1'b0);
    tick();
    for (int c = 0; c < 24; c++) begin
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    checks++; if (Stall_Cnt !== CNT_W'(PERF ? MAXC : 0)) begin errors++; $display("FAIL sat_stall got=%0d exp=%0d", Stall_Cnt, PERF ? MAXC : 0); end
    checks++; if (Bubble_Cnt !== '0) begin errors++; $display("FAIL sat_bubble got=%0d exp=0", Bubble_Cnt); end
    checks++; if (Out_Data !== 32'h77) begin errors++; $display("FAIL sat_data got=%h exp=77", Out_Data); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, W'($urandom),
            $urandom_range(0, 15) == 0,
            ($urandom_range(0, 7) == 0) ? D'($urandom_range(0, 15)) : D'(0),
            $urandom_range(0, 2) != 0);
      checks++; if (In_Ready !== e_in_ready) begin errors++; $display("FAIL rnd_in_ready c=%0d got=%b exp=%b", c, In_Ready, e_in_ready); end
      checks++; if (Out_Valid !== e_out_valid) begin errors++; $display("FAIL rnd_out_valid c=%0d got=%b exp=%b", c, Out_Valid, e_out_valid); end
      checks++; if (Out_Data !== e_out_data) begin errors++; $display("FAIL rnd_out_data c=%0d got=%h exp=%h", c, Out_Data, e_out_data); end
      checks++; if (Count !== 3'(e_count)) begin errors++; $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, Count, e_count); end
      checks++; if (Stall_Cnt !== CNT_W'(e_stall)) begin errors++; $display("FAIL rnd_stall c=%0d got=%0d exp=%0d", c, Stall_Cnt, e_stall); end
      checks++; if (Bubble_Cnt !== CNT_W'(e_bub)) begin errors++; $display("FAIL rnd_bubble c=%0d got=%0d exp=%0d", c, Bubble_Cnt, e_bub); end
      tick();
    end
  endtask

  initial begin
    Reset = 1'b1; In_Valid = 1'b0; In_Data = '0; Flush_In = 1'b0;
    Flush_Mask = '0; Out_Ready = 1'b0;
    for (int i = 0; i < D; i++) begin m_v[i] = 1'b0; m_d[i] = '0; end
    test_reset();
    test_stream();
    test_stall();
    test_flush_mask();
    test_flush_in();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
